sbox_share_ctrl: RTL
====================

# sbox_share_ctrl

Round-robin scheduler that shares a single `aes_sbox_lut` instance among several requesters, each submitting a multi-byte word for byte-wise substitution. It accepts one word at a time and pushes its bytes through the S-box one per cycle. The substituted word returns on a single response channel, tagged with the requester index. The block sits between the hash round logic (the requesters) and the S-box datapath, so the design carries one S-box instead of one per requester.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `BYTES`, default 4: bytes per word; legal range 1..16.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `req_valid` input, NUM_REQ: per-requester request strobe.
- `req_data` input, NUM_REQ*BYTES*8: packed words; requester i occupies slice [i*BYTES*8 +: BYTES*8].
- `req_ready` output, NUM_REQ: one-hot accept strobe.
- `rsp_valid` output, 1: substituted word available.
- `rsp_ready` input, 1: consumer accepts the response.
- `rsp_data` output, BYTES*8: substituted word.
- `rsp_id` output, max(1,$clog2(NUM_REQ)): index of the requester that owns `rsp_data`.
- `busy` output, 1: high in every state except IDLE.

## Operation
- States are IDLE, SUB and RESP.
- **IDLE**
  - If any `req_valid` is high, the winner is the first set bit found by searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` is driven combinationally in the same cycle. The handshake is `valid & ready`.
  - On the handshake edge: latch the winner's word into `work` and the winner's index into `id_q`; clear `byte_cnt`; go to SUB.
  - No `req_valid` high: stay in IDLE.
- **SUB**
  - Each cycle, `work[byte_cnt*8 +: 8]` is replaced by the S-box output for that byte. Byte 0 is bits [7:0].
  - `byte_cnt` increments each cycle. After byte BYTES-1 is written, go to RESP.
  - `req_ready` is all zero.
- **RESP**
  - `rsp_valid`=1, `rsp_data`=`work`, `rsp_id`=`id_q`; all three are held stable until `rsp_ready`.
  - On the `rsp_valid & rsp_ready` edge: `rr_ptr` ← (`id_q`+1) mod NUM_REQ; go to IDLE.
- Requester rules:
  - A requester must hold `req_valid` and its data stable until it is granted.
  - A request withdrawn while another request is in flight is simply not served.
  - The block never depends on a requester deasserting.
- `rsp_valid`, `rsp_data` and `rsp_id` are registered outputs. `req_ready` is combinational from state, `req_valid` and `rr_ptr` only. There is no combinational path from `rsp_ready` to any output.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, `rr_ptr`=0, `byte_cnt`=0, `work`=0, `id_q`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `req_ready`=0 while `rst_n` is low.
- Latency, default build: accept handshake in cycle T → `rsp_valid` first high in cycle T+BYTES+1.
- With `SBOX_IN_REG_EN`: first high in cycle T+BYTES+2.
- Throughput: one word per BYTES+2 cycles when `rsp_ready` is tied high. A new accept is possible only in the cycle after the response handshake (IDLE).
- Simultaneous requests: exactly one grant per accept; the others wait, and fairness is guaranteed by `rr_ptr`.
- Reset mid-SUB or mid-RESP: the in-flight word is discarded with no response, and `rr_ptr` returns to 0.
- `byte_cnt` width is max(1,$clog2(BYTES)). For BYTES=1, SUB lasts exactly one cycle.

## Configuration
- Macro `SBOX_IN_REG_EN`.
- Defined:
  - A byte register is inserted between `work` and the S-box input.
  - SUB issues byte k in cycle k and writes it back in cycle k+1, so SUB lasts BYTES+1 cycles.
  - Results are identical.
- Undefined: the S-box is fed combinationally from `work`, and SUB lasts BYTES cycles.

## Structure
- Package `sbox_ctrl_pkg` contains:
  - the state enum `sbox_ctrl_state_e` (IDLE, SUB, RESP);
  - the constant `SBOX_BYTE_W`=8;
  - the function `rr_pick(valid, ptr)` returning the winner index.
- Sub-module `sbox_rr_arbiter`: combinational round-robin pick, with inputs valid and ptr and outputs a one-hot grant and an index.
- The block instantiates one `aes_sbox_lut`.

## Test plan
- **Single word.** Requester 0 sends 0x00010203 with `rsp_ready`=1.
  - Required: `rsp_data`=0x637c777b and `rsp_id`=0.
  - `rsp_valid` is high exactly 5 cycles after the accept (6 with `SBOX_IN_REG_EN`).
- **Boundary bytes.** Requester 2 sends 0x5352ff00.
  - Required: `rsp_data`=0xed001663 and `rsp_id`=2.
- **Fairness.** All 4 `req_valid` are held high continuously.
  - Required: grant order 0,1,2,3,0,1, with `req_ready` one-hot on each grant.
- **Backpressure.** `rsp_ready` is held low for 10 cycles after `rsp_valid`.
  - Required: `rsp_data` and `rsp_id` stay stable, `busy`=1, and `req_ready`=0 throughout.
  - Required: the handshake completes on the first `rsp_ready`=1 cycle.
- **Reset mid-operation.** `rst_n` is pulled low during SUB byte 2.
  - Required: all outputs are 0 immediately, no response is ever emitted, and after release requester 1 alone is granted first.
- **Pointer wrap.** Requester 3 is served.
  - Required: with requesters 0 and 3 both pending next, requester 0 is granted.

Source files
------------

// File: rtl/sbox_ctrl_pkg.sv
// Shared types and helpers for the S-box sharing controller.
package sbox_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        RESP
    } sbox_ctrl_state_e;

    localparam int SBOX_BYTE_W = 8;
    localparam int MAX_REQ     = 16;
    localparam int RR_IDX_W    = 4;

    // Lanes past NUM_REQ are zero-padded by the caller, so a mod-16 search preserves mod-NUM_REQ order.
    function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                    input logic [RR_IDX_W-1:0] ptr);
        logic [RR_IDX_W-1:0] cand;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            cand = ptr + RR_IDX_W'(i);
            if (valid[cand]) rr_pick = cand;
        end
    endfunction

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// Request/response bundle between the round logic (master) and the S-box controller (slave).
interface sbox_share_ctrl_if
    import sbox_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BYTES   = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ*BYTES*SBOX_BYTE_W-1:0]   req_data;
    logic [NUM_REQ-1:0]                     req_ready;
    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [BYTES*SBOX_BYTE_W-1:0]           rsp_data;
    logic [IDW-1:0]                         rsp_id;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/aes_sbox_lut.sv
// AES forward S-box as a 256-entry constant table.
module aes_sbox_lut (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sbox_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant plus index, searching upward from ptr.
module sbox_rr_arbiter
    import sbox_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx
);

    logic [MAX_REQ-1:0]  valid_pad;
    logic [RR_IDX_W-1:0] pick;

    always_comb begin
        valid_pad = '0;
        valid_pad[NUM_REQ-1:0] = valid;
        pick  = rr_pick(valid_pad, RR_IDX_W'(ptr));
        idx   = IDW'(pick);
        grant = '0;
        if (valid != '0) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Round-robin sharing of one AES S-box among NUM_REQ requesters, one byte per cycle.
// Define SBOX_IN_REG_EN to register the S-box input byte (SUB then lasts BYTES+1 cycles).
module sbox_share_ctrl
    import sbox_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BYTES   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sbox_share_ctrl_if.slave    bus,
    output logic                busy
);

    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WORD_W = BYTES * SBOX_BYTE_W;

    sbox_ctrl_state_e state, state_next;

    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         id_q;
    logic [IDW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [CW-1:0]          byte_cnt;
    logic [WORD_W-1:0]      work;
    logic                   rsp_valid_q;
    logic [SBOX_BYTE_W-1:0] sbox_in;
    logic [SBOX_BYTE_W-1:0] sbox_out;
    logic                   accept;
    logic                   rsp_done;
    logic                   sub_last;

    sbox_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    aes_sbox_lut u_sbox (
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    assign accept   = (state == IDLE) && (bus.req_valid != '0);
    assign rsp_done = rsp_valid_q && bus.rsp_ready;

`ifdef SBOX_IN_REG_EN
    logic [SBOX_BYTE_W-1:0] in_q;
    logic [CW-1:0]          wb_idx;
    logic                   wb_valid;
    logic                   issue_done;

    assign sbox_in  = in_q;
    assign sub_last = wb_valid && (wb_idx == CW'(BYTES - 1));
`else
    assign sbox_in  = work[int'(byte_cnt)*SBOX_BYTE_W +: SBOX_BYTE_W];
    assign sub_last = (byte_cnt == CW'(BYTES - 1));
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = work;
    assign bus.rsp_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // rst_n gates the grant so req_ready stays low while reset is held, even with requests pending.
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (rst_n) bus.req_ready = grant;
                if (accept) state_next = SUB;
            end
            SUB:     if (sub_last) state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            id_q        <= '0;
            byte_cnt    <= '0;
            work        <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SBOX_IN_REG_EN
            in_q        <= '0;
            wb_idx      <= '0;
            wb_valid    <= 1'b0;
            issue_done  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work     <= bus.req_data[int'(grant_idx)*WORD_W +: WORD_W];
                        id_q     <= grant_idx;
                        byte_cnt <= '0;
`ifdef SBOX_IN_REG_EN
                        wb_valid   <= 1'b0;
                        issue_done <= 1'b0;
`endif
                    end
                end
                SUB: begin
`ifdef SBOX_IN_REG_EN
                    // Issue byte k into in_q while byte k-1 returns from the S-box into work.
                    if (!issue_done) begin
                        in_q       <= work[int'(byte_cnt)*SBOX_BYTE_W +: SBOX_BYTE_W];
                        wb_idx     <= byte_cnt;
                        wb_valid   <= 1'b1;
                        byte_cnt   <= byte_cnt + 1'b1;
                        issue_done <= (byte_cnt == CW'(BYTES - 1));
                    end
                    if (wb_valid) work[int'(wb_idx)*SBOX_BYTE_W +: SBOX_BYTE_W] <= sbox_out;
                    if (sub_last) wb_valid <= 1'b0;
`else
                    work[int'(byte_cnt)*SBOX_BYTE_W +: SBOX_BYTE_W] <= sbox_out;
                    byte_cnt <= byte_cnt + 1'b1;
`endif
                    if (sub_last) rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid_q <= 1'b0;
                        rr_ptr      <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
